game_ctrl: RTL
==============

# game_ctrl

Game-level sequencer for the frogger design: it consumes the frog/car overlap flag and the frog's goal flag, and produces the `state` code and `reset` pulse that drive the frog and cars modules. It also maintains lives, score and level. Level is exported for car-speed scaling and HUD rendering. All decisions are taken once per video frame, so combinational glitches on the collision path are never acted on.

## Interface
Parameters:
- `START_LIVES`, 3: lives loaded at game start (1..3).
- `DEATH_FRAMES`, 60: frames spent in DYING before respawn or game over.
- `WIN_FRAMES`, 30: frames spent in WIN before the next round.
- `MAX_LEVEL`, 7: saturation value of `level`.

Ports:
- `clk`, in, 1: 25.175 MHz pixel clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `frame_tick`, in, 1: one-cycle pulse per frame, asserted at VSYNC start.
- `collision`, in, 1: frog/car overlap, combinational, may glitch.
- `reached_end`, in, 1: frog occupies the goal row.
- `button_start`, in, 1: raw, asynchronous button, active-high. The OR of all four d-pad buttons is wired here.
- `state`, out, 2: `game_state_t` code: IDLE=00, PLAY=01, DYING=10, WIN=11.
- `round_reset`, out, 1: one-cycle pulse that re-initialises frog position and car positions.
- `lives`, out, 2: remaining lives.
- `score`, out, 8: rounds completed, saturating at 255.
- `level`, out, 3: difficulty, saturating at `MAX_LEVEL`.
- `game_over`, out, 1: high while in IDLE after lives have reached 0.

## Operation
- `button_start` passes through a two-flop synchroniser and a rising-edge detector, giving `start_rise`.
- `collision` and `reached_end` are sampled only in cycles where `frame_tick`=1. All other cycles ignore them.
- Frame counter `fcnt`, 7 bits:
  - cleared on every state transition;
  - increments on `frame_tick` while in DYING or WIN.

State transitions (FSM):
- **IDLE → PLAY** on `start_rise`. Loads `lives`=`START_LIVES`, `score`=0, `level`=0, clears `game_over`, pulses `round_reset`.
- **PLAY → DYING** on `frame_tick` & `collision`. Decrements `lives`.
- **PLAY → WIN** on `frame_tick` & `reached_end` & !`collision`. Collision has priority when both are set.
- **DYING, `fcnt` reaches `DEATH_FRAMES`-1 on `frame_tick`:**
  - if `lives`≠0: → PLAY and pulse `round_reset`;
  - if `lives`=0: → IDLE and set `game_over`.
- **WIN, `fcnt` reaches `WIN_FRAMES`-1 on `frame_tick`:** → PLAY. `score`+1 (saturating), `level`+1 (saturating at `MAX_LEVEL`), pulse `round_reset`.
- `start_rise` outside IDLE is ignored.
- `lives` never underflows. DYING is entered only from PLAY, where `lives`≥1 always holds.

## Timing
- Reset values (asynchronous, while `reset_n`=0): `state`=IDLE, `round_reset`=0, `lives`=0, `score`=0, `level`=0, `game_over`=0, `fcnt`=0, synchroniser flops=0.
- All outputs are registered.
- Latency:
  - `state`, `lives`, `score`, `level` update in the cycle after the qualifying `frame_tick` edge;
  - `round_reset` is high in that same cycle, for exactly one `clk` cycle.
- Button to `start_rise`: 3 clk cycles (2 sync + 1 edge register). Transition to PLAY follows on the next edge.
- The collision flag is next sampled at least one full frame after `round_reset`, so a stale overlap from before the respawn cannot kill the frog.
- Simultaneous `frame_tick` and `start_rise` in IDLE: the start is taken. `frame_tick` has no effect in IDLE.
- Reset asserted mid-game returns the block to IDLE with all counters cleared. No `round_reset` pulse is emitted.
- Release of `reset_n` must be synchronised externally to `clk`. The block assumes a clean deassertion.

## Structure
- Shared package `game_pkg` holds:
  - `typedef enum logic [1:0] game_state_t`;
  - `BLOCKSIZE`, and lane Y constants shared with collision/render.
- Sub-module `btn_edge` (synchroniser + rising-edge detect, same `clk`/`reset_n`). It is reused later for the d-pad inputs of `frog`.
- FSM, frame counter and the score/level/lives registers live in `game_ctrl` itself.

## Test plan
- **Start:** reset, then pulse `button_start` high for 5 cycles → after 4 cycles `state`=01, `lives`=3, `score`=0, and `round_reset` is high for exactly 1 cycle.
- **Death:** in PLAY, hold `collision`=1 across one `frame_tick` → `state`=10, `lives`=2. After 60 further ticks: `state`=01, `round_reset` pulses once.
- **Glitch rejection:** in PLAY, pulse `collision` for 3 cycles between ticks → `state` stays 01 and `lives` is unchanged.
- **Win with priority:**
  - `reached_end`=1 and `collision`=1 on the same tick → DYING.
  - `reached_end` alone → WIN. After 30 ticks: `score`=1, `level`=1, `state`=01.
- **Game over:** three successive deaths → after the third DYING, `state`=00, `game_over`=1, `lives`=0. The next `start_rise` gives `lives`=3 and `game_over`=0.
- **Saturation/reset:**
  - 9 wins → `level`=7.
  - Preloaded `score`=255 plus a win → `score` stays 255.
  - Assert `reset_n`=0 mid-DYING → all outputs at reset values immediately, with no `round_reset`.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and playfield geometry for the frogger blocks
//   game_state_t : game_ctrl state code exported on its state port
//   BLOCKSIZE    : edge length of one playfield tile in pixels
//   *_Y          : top pixel row of the goal, car lanes and start row
package game_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    DYING = 2'b10,
    WIN   = 2'b11
  } game_state_t;
  localparam int BLOCKSIZE = 32;
  localparam int GOAL_Y    = 0;
  localparam int LANE0_Y   = 2 * BLOCKSIZE;
  localparam int LANE1_Y   = 4 * BLOCKSIZE;
  localparam int LANE2_Y   = 6 * BLOCKSIZE;
  localparam int LANE3_Y   = 8 * BLOCKSIZE;
  localparam int LANE4_Y   = 10 * BLOCKSIZE;
  localparam int START_Y   = 14 * BLOCKSIZE;
  function automatic int lane_y(input int idx);
    return LANE0_Y + 2 * BLOCKSIZE * idx;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchroniser plus registered rising-edge detect for a raw button
//   clk, reset_n : clock and asynchronous active-low reset
//   btn_i        : raw asynchronous button, active-high
//   rise_o       : one-cycle pulse, three clocks after btn_i rises
module btn_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic rise_o
);
  // sync_q[1] is the first metastability-safe copy, sync_q[2] its previous value
  logic [2:0] sync_q;
  logic       rise_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], btn_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end
  assign rise_o = rise_q;
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-paced game sequencer tracking lives, score and level
//   clk, reset_n        : pixel clock, asynchronous active-low reset
//   frame_tick          : one pulse per frame; collision/reached_end only looked at here
//   collision           : frog/car overlap (may glitch between ticks)
//   reached_end         : frog is on the goal row
//   button_start        : raw start button (OR of the d-pad)
//   state               : IDLE/PLAY/DYING/WIN code
//   round_reset         : one-cycle pulse re-initialising frog and cars
//   lives, score, level : game counters; score and level saturate
//   game_over           : set when the last life is lost, cleared on the next start
module game_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 30,
  parameter int MAX_LEVEL    = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       reached_end,
  input  logic       button_start,
  output logic [1:0] state,
  output logic       round_reset,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] level,
  output logic       game_over
);
  logic        start_rise;
  game_state_t state_q, state_d;
  logic [6:0]  fcnt_q, fcnt_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  level_q, level_d;
  logic        go_q, go_d;
  logic        rr_q, rr_d;
  btn_edge u_start (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_i  (button_start),
    .rise_o (start_rise)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      lives_q <= '0;
      score_q <= '0;
      level_q <= '0;
      go_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      lives_q <= lives_d;
      score_q <= score_d;
      level_q <= level_d;
      go_q    <= go_d;
      rr_q    <= rr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    go_d    = go_q;
    rr_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start_rise) begin
        state_d = PLAY;
        fcnt_d  = '0;
        lives_d = 2'(START_LIVES);
        score_d = '0;
        level_d = '0;
        go_d    = 1'b0;
        rr_d    = 1'b1;
      end
      // collision wins over reached_end on the same tick
      PLAY: if (frame_tick && collision) begin
        state_d = DYING;
        fcnt_d  = '0;
        lives_d = lives_q - 2'd1;
      end else if (frame_tick && reached_end) begin
        state_d = WIN;
        fcnt_d  = '0;
      end
      DYING: if (frame_tick) begin
        fcnt_d = fcnt_q + 7'd1;
        if (fcnt_q == 7'(DEATH_FRAMES - 1)) begin
          fcnt_d  = '0;
          state_d = (lives_q != 2'd0) ? PLAY : IDLE;
          rr_d    = (lives_q != 2'd0);
          go_d    = (lives_q == 2'd0);
        end
      end
      WIN: if (frame_tick) begin
        fcnt_d = fcnt_q + 7'd1;
        if (fcnt_q == 7'(WIN_FRAMES - 1)) begin
          fcnt_d  = '0;
          state_d = PLAY;
          rr_d    = 1'b1;
          score_d = (score_q != 8'hff) ? score_q + 8'd1 : score_q;
          level_d = (level_q != 3'(MAX_LEVEL)) ? level_q + 3'd1 : level_q;
        end
      end
    endcase
  end
  assign state       = state_q;
  assign round_reset = rr_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign level       = level_q;
  assign game_over   = go_q;
endmodule
